pu_seq: RTL

- Multi-cycle sequencer for the 16-bit processing unit.
- Fetches an instruction word over an instruction-memory handshake and holds it in the instruction register that feeds the decoder.
- Converts the decoder's combinational strobes (we, pcwe, dmwe, dms, h) into single-cycle commit pulses for the register file, flags, PC and data memory.
- Provides halt, fault and retired-instruction reporting for the testbench and the debug console.

---
 rtl/pu_seq_pkg.sv | 31 +++
 rtl/pu_seq_tmo.sv | 31 +++
 rtl/pu_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pu_seq_pkg.sv
// Shared types and constants for the pu_seq multi-cycle sequencer.
// Optional single-step support is enabled by defining PU_SEQ_STEP_EN.
package pu_seq_pkg;

  localparam int unsigned IW_DEF   = 16;
  localparam int unsigned CNTW_DEF = 16;
  localparam int unsigned TMO_DEF  = 15;
  localparam int unsigned TMOW     = 8;   // wait counter covers TMO up to 255

  // Control levels shared with pu.vh
  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_HALT   = 4'd6,
    ST_FAULT  = 4'd7,
    ST_PAUSE  = 4'd8
  } state_e;

  // Any state that is actively sequencing an instruction
  function automatic logic is_busy(input state_e s);
    return !((s == ST_IDLE) || (s == ST_HALT) || (s == ST_FAULT));
  endfunction

endpackage

// File: rtl/pu_seq_tmo.sv
// Wait counter shared by the instruction-fetch and data-memory waits.
// expired_c flags the wait cycle on which the count reaches TMO.
module seq_tmo
  import pu_seq_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [TMOW-1:0] cnt;

  // Count non-ack wait cycles; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMOW'(1);
    end
  end

  // This wait cycle brings the count up to TMO
  assign expired_c = en && (cnt == TMOW'(TMO - 1));

endmodule

// File: rtl/pu_seq.sv
// pu_seq: multi-cycle fetch/decode/execute sequencer for the 16-bit PU.
// Define PU_SEQ_STEP_EN to add step_mode/step ports and the PAUSE state.
module pu_seq
  import pu_seq_pkg::*;
#(
  parameter int unsigned IW   = IW_DEF,
  parameter int unsigned CNTW = CNTW_DEF,
  parameter int unsigned TMO  = TMO_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef PU_SEQ_STEP_EN
  input  logic            step_mode,
  input  logic            step,
`endif
  output logic            im_req,
  input  logic            im_ack,
  input  logic [IW-1:0]   im_rdata,
  output logic [IW-1:0]   ir,
  input  logic            dec_h,
  input  logic            dec_we,
  input  logic            dec_pcwe,
  input  logic            dec_dmwe,
  input  logic            dec_dms,
  output logic            rf_we,
  output logic            flag_we,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            dm_req,
  output logic            dm_we,
  input  logic            dm_ack,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [CNTW-1:0] icount
);

  state_e state;
  state_e state_nxt;
  state_e retire_nxt;
  logic   tmo_en;
  logic   tmo_exp;
  logic   retire;

  // Shared wait counter runs only while a handshake is outstanding
  assign tmo_en = ((state == ST_FETCH) && !im_ack) || ((state == ST_MEM) && !dm_ack);

  seq_tmo #(.TMO(TMO)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!tmo_en),
    .en        (tmo_en),
    .expired_c (tmo_exp)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and single-cycle commit pulses
  always_comb begin
    state_nxt  = state;
    retire_nxt = ST_FETCH;
    rf_we      = NEGATE;
    flag_we    = NEGATE;
    pc_inc     = NEGATE;
    pc_load    = NEGATE;
    dm_we      = NEGATE;
    retire     = NEGATE;
`ifdef PU_SEQ_STEP_EN
    if (step_mode) begin
      retire_nxt = ST_PAUSE;
    end
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (im_ack) begin
          state_nxt = ST_DECODE;
        end else if (tmo_exp) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (dec_h) begin
          state_nxt = ST_HALT;
        end else if (dec_dms) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rf_we     = dec_we;
        flag_we   = dec_we;
        pc_load   = dec_pcwe;
        pc_inc    = !dec_pcwe;
        retire    = ASSERT;
        state_nxt = retire_nxt;
      end
      ST_MEM: begin
        dm_we = dec_dmwe;
        if (dm_ack) begin
          state_nxt = ST_WB;
        end else if (tmo_exp) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_WB: begin
        rf_we     = dec_we;
        pc_inc    = ASSERT;
        retire    = ASSERT;
        state_nxt = retire_nxt;
      end
      ST_HALT:  state_nxt = ST_HALT;
      ST_FAULT: state_nxt = ST_FAULT;
`ifdef PU_SEQ_STEP_EN
      ST_PAUSE: begin
        if (step || !step_mode) begin
          state_nxt = ST_FETCH;
        end
      end
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore status/request outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_req <= NEGATE;
      dm_req <= NEGATE;
      busy   <= NEGATE;
      halted <= NEGATE;
      fault  <= NEGATE;
    end else begin
      im_req <= (state_nxt == ST_FETCH);
      dm_req <= (state_nxt == ST_MEM);
      busy   <= is_busy(state_nxt);
      halted <= (state_nxt == ST_HALT);
      fault  <= (state_nxt == ST_FAULT);
    end
  end

  // Instruction register loads only on the fetch acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if ((state == ST_FETCH) && im_ack) begin
      ir <= im_rdata;
    end
  end

  // Retired-instruction counter, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icount <= '0;
    end else if (retire && (icount != '1)) begin
      icount <= icount + CNTW'(1);
    end
  end

endmodule
